// File: rtl/pll_1_if.sv
// pll_1_if: side-band bundle between the pll_1 divider/lock block and its consumer.
//   pll_pwd  : synchronous active-high power-down request (consumer -> pll_1)
//   clkout0  : divided output clock, registered (pll_1 -> consumer)
//   pll_lock : sticky lock indicator, registered (pll_1 -> consumer)
// The master modport is the pll_1 side; the slave modport is the consumer side.
interface pll_1_if;
    logic pll_pwd;
    logic clkout0;
    logic pll_lock;

    modport master (
        input  pll_pwd,
        output clkout0,
        output pll_lock
    );

    modport slave (
        output pll_pwd,
        input  clkout0,
        input  pll_lock
    );
endinterface

// File: rtl/pll_1.sv
// pll_1: behavioural PLL stand-in built from a clock divider and a lock timer.
// Parameters:
//   ODIV0       : divide ratio clkin1 -> clkout0, legal 2..1024
//   LOCK_CYCLES : clkin1 rising edges after reset release until pll_lock, legal 1..65535
// Ports:
//   clkin1      : reference clock, all state on its rising edge
//   pll_rst     : synchronous active-high reset
//   bus.pll_pwd : synchronous active-high power-down, same effect as pll_rst
//   bus.clkout0 : divided clock, high for floor(ODIV0/2) of every ODIV0 cycles
//   bus.pll_lock: goes high on the LOCK_CYCLES-th edge after release, sticky until reset
module pll_1 #(
    parameter int unsigned ODIV0       = 4,
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic     clkin1,
    input  logic     pll_rst,
    pll_1_if.master  bus
);
    localparam int unsigned    DivW     = (ODIV0 > 1) ? $clog2(ODIV0) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(ODIV0 - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(ODIV0 / 2);
    localparam logic [DivW-1:0] DivOne  = DivW'(1);
    localparam logic [15:0]     LockTgt = 16'(LOCK_CYCLES);

    logic            rst;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [15:0]     lock_cnt_q, lock_cnt_d;
    logic            clkout0_q, clkout0_d;
    logic            pll_lock_q, pll_lock_d;

    assign rst = pll_rst | bus.pll_pwd;

    always_comb begin
        div_cnt_d  = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivOne;
        // Counter is 0 on the first edge after release, so clkout0 rises there.
        clkout0_d  = (div_cnt_q < DivHalf);
        lock_cnt_d = (lock_cnt_q == LockTgt) ? lock_cnt_q : lock_cnt_q + 16'd1;
        // Compare against the incremented count so lock lands on the
        // LOCK_CYCLES-th edge itself; once set it only clears on reset.
        pll_lock_d = pll_lock_q | (lock_cnt_d == LockTgt);
    end

    always_ff @(posedge clkin1) begin
        if (rst) begin
            div_cnt_q  <= '0;
            lock_cnt_q <= '0;
            clkout0_q  <= 1'b0;
            pll_lock_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            clkout0_q  <= clkout0_d;
            pll_lock_q <= pll_lock_d;
        end
    end

    assign bus.clkout0  = clkout0_q;
    assign bus.pll_lock = pll_lock_q;
endmodule

// File: tb/tb_pll_1.sv
// tb_pll_1: self-checking bench for pll_1 with three configurations sharing one
// clock and reset: (ODIV0=4, LOCK=64), (ODIV0=5, LOCK=64), (ODIV0=7, LOCK=1).
// The reference model counts rising edges since reset release and derives the
// expected clkout0/pll_lock values arithmetically from that count.
`timescale 1ns/1ps
module tb_pll_1;
    logic clk_tb;
    logic pll_rst;
    logic pll_pwd;
    int   checks;
    int   errors;
    int   n;            // edges since last reset release (0 = in reset)
    logic [5:0] got;

    pll_1_if bus0 ();
    pll_1_if bus5 ();
    pll_1_if bus7 ();

    assign bus0.pll_pwd = pll_pwd;
    assign bus5.pll_pwd = pll_pwd;
    assign bus7.pll_pwd = pll_pwd;

    pll_1 #(.ODIV0(4), .LOCK_CYCLES(64)) u_dut0 (.clkin1(clk_tb), .pll_rst(pll_rst), .bus(bus0));
    pll_1 #(.ODIV0(5), .LOCK_CYCLES(64)) u_dut5 (.clkin1(clk_tb), .pll_rst(pll_rst), .bus(bus5));
    pll_1 #(.ODIV0(7), .LOCK_CYCLES(1))  u_dut7 (.clkin1(clk_tb), .pll_rst(pll_rst), .bus(bus7));

    assign got = {bus0.clkout0, bus0.pll_lock, bus5.clkout0, bus5.pll_lock,
                  bus7.clkout0, bus7.pll_lock};

    initial clk_tb = 1'b0;
    always #10 clk_tb = ~clk_tb;

    function automatic logic m_clk(int k, int div);
        if (k == 0) return 1'b0;
        return ((k - 1) % div) < (div / 2);
    endfunction

    function automatic logic m_lock(int k, int lc);
        return (k >= lc);
    endfunction

    function automatic logic [5:0] exp_vec(int k);
        return {m_clk(k, 4), m_lock(k, 64), m_clk(k, 5), m_lock(k, 64),
                m_clk(k, 7), m_lock(k, 1)};
    endfunction

    // Advance one clkin1 edge, update the model, return 1 ns after the edge.
    task automatic step();
        logic r;
        r = pll_rst | pll_pwd;
        @(posedge clk_tb);
        if (r) n = 0;
        else   n++;
        #1;
    endtask

    task automatic test_reset();
        pll_rst = 1'b1;
        pll_pwd = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs got=%b exp=%b", got, 6'b0);
            end
        end
    endtask

    task automatic test_default();
        int rises, rise_at;
        logic prev;
        rises = 0; rise_at = -1; prev = 1'b0;
        pll_rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            checks++;
            if (got !== exp_vec(n)) begin
                errors++;
                $display("FAIL default_seq edge=%0d got=%b exp=%b", n, got, exp_vec(n));
            end
            if (!prev && bus0.pll_lock === 1'b1) begin
                rises++;
                rise_at = n;
            end
            prev = bus0.pll_lock;
        end
        checks++;
        if (rises !== 1 || rise_at !== 64) begin
            errors++;
            $display("FAIL default_lock_rise rises=%0d at=%0d exp rises=1 at=64", rises, rise_at);
        end
    endtask

    task automatic test_odiv5();
        longint t_prev, t_now;
        int     periods;
        logic   prev;
        t_prev = -1; periods = 0; prev = bus5.clkout0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (got !== exp_vec(n)) begin
                errors++;
                $display("FAIL odiv5_seq edge=%0d got=%b exp=%b", n, got, exp_vec(n));
            end
            if (!prev && bus5.clkout0 === 1'b1) begin
                t_now = $time;
                if (t_prev >= 0) begin
                    periods++;
                    checks++;
                    if (t_now - t_prev !== 100) begin
                        errors++;
                        $display("FAIL odiv5_period got=%0d exp=100", t_now - t_prev);
                    end
                end
                t_prev = t_now;
            end
            prev = bus5.clkout0;
        end
        checks++;
        if (periods !== 7) begin
            errors++;
            $display("FAIL odiv5_period_count got=%0d exp=7", periods);
        end
    endtask

    task automatic test_rst_pulse();
        int rises, rise_at;
        logic prev;
        repeat ($urandom_range(0, 7)) step();
        pll_rst = 1'b1;
        step();
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL rst_pulse_edge got=%b exp=%b", got, 6'b0);
        end
        pll_rst = 1'b0;
        rises = 0; rise_at = -1; prev = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            checks++;
            if (got !== exp_vec(n)) begin
                errors++;
                $display("FAIL rst_pulse_seq edge=%0d got=%b exp=%b", n, got, exp_vec(n));
            end
            if (!prev && bus0.pll_lock === 1'b1) begin
                rises++;
                rise_at = n;
            end
            prev = bus0.pll_lock;
        end
        checks++;
        if (rises !== 1 || rise_at !== 64) begin
            errors++;
            $display("FAIL rst_pulse_relock rises=%0d at=%0d exp rises=1 at=64", rises, rise_at);
        end
    endtask

    task automatic test_pwd();
        int rises;
        logic prev;
        pll_pwd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL pwd_hold cycle=%0d got=%b exp=%b", i, got, 6'b0);
            end
        end
        pll_pwd = 1'b0;
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            checks++;
            if (got !== exp_vec(n)) begin
                errors++;
                $display("FAIL pwd_release edge=%0d got=%b exp=%b", n, got, exp_vec(n));
            end
            if (!prev && bus0.pll_lock === 1'b1) rises++;
            prev = bus0.pll_lock;
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL pwd_lock_rises got=%0d exp=1", rises);
        end
    endtask

    task automatic test_both();
        pll_rst = 1'b1;
        pll_pwd = 1'b1;
        repeat (2) begin
            step();
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL both_hold got=%b exp=%b", got, 6'b0);
            end
        end
        pll_rst = 1'b0;
        pll_pwd = 1'b0;
        step();
        checks++;
        if (bus7.pll_lock !== 1'b1) begin
            errors++;
            $display("FAIL both_lock1_first_edge got=%b exp=1", bus7.pll_lock);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (got !== exp_vec(n)) begin
                errors++;
                $display("FAIL both_seq edge=%0d got=%b exp=%b", n, got, exp_vec(n));
            end
            step();
        end
    endtask

    task automatic test_long_run();
        int     falls;
        logic   prev_lock, prev_clk;
        longint t_prev, t_now;
        repeat (70) step();
        falls = 0; prev_lock = bus0.pll_lock; prev_clk = bus0.clkout0; t_prev = -1;
        for (int i = 0; i < 20000; i++) begin
            step();
            checks++;
            if (got !== exp_vec(n)) begin
                errors++;
                $display("FAIL long_seq edge=%0d got=%b exp=%b", n, got, exp_vec(n));
            end
            if (prev_lock && bus0.pll_lock !== 1'b1) falls++;
            prev_lock = bus0.pll_lock;
            if (!prev_clk && bus0.clkout0 === 1'b1) begin
                t_now = $time;
                if (t_prev >= 0) begin
                    checks++;
                    if (t_now - t_prev !== 80) begin
                        errors++;
                        $display("FAIL long_period got=%0d exp=80", t_now - t_prev);
                    end
                end
                t_prev = t_now;
            end
            prev_clk = bus0.clkout0;
        end
        checks++;
        if (falls !== 0) begin
            errors++;
            $display("FAIL long_lock_falls got=%0d exp=0", falls);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pll_rst = ($urandom_range(0, 399) == 0);
            pll_pwd = ($urandom_range(0, 399) == 0);
            step();
            checks++;
            if (got !== exp_vec(n)) begin
                errors++;
                $display("FAIL random_seq cycle=%0d edge=%0d got=%b exp=%b",
                         i, n, got, exp_vec(n));
            end
        end
        pll_rst = 1'b0;
        pll_pwd = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        n       = 0;
        pll_rst = 1'b1;
        pll_pwd = 1'b0;
        test_reset();
        test_default();
        test_odiv5();
        test_rst_pulse();
        test_pwd();
        test_both();
        test_long_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
